dmem_responder: RTL and testbench

Data-memory responder that serves the pipelined CPU's MEM-stage load and store requests over a valid/ready request channel and a valid/ready response channel.
- Stores DEPTH_BYTES bytes in big-endian order.
- Supports 1/2/4/8-byte transfers.
- Adds a programmable access latency, so the CPU's stall logic can be exercised against realistic memory timing.
- Flags misaligned, out-of-range and bad-size requests instead of performing them.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_byte_array.sv | 43 ++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned SIZE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [SIZE_W-1:0] SZ_B = 4'd1;
    localparam logic [SIZE_W-1:0] SZ_H = 4'd2;
    localparam logic [SIZE_W-1:0] SZ_W = 4'd4;
    localparam logic [SIZE_W-1:0] SZ_D = 4'd8;

    // Request fields captured at acceptance and used at the commit edge.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
    } req_t;

    function automatic logic size_legal(input logic [SIZE_W-1:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [SIZE_W-1:0] size);
        case (size)
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            SZ_D:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with big-endian sized read (combinational) and sized write.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     addr,
    input  logic [SIZE_W-1:0] size,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    logic [7:0] mem [DEPTH_BYTES];

    // mem[addr] lands in the most significant byte of the result.
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(size)) begin
                rdata_c = {rdata_c[DATA_W-9:0], mem[addr + AW'(i)]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
                mem[AW'(i)] <= 8'h00;
            end
        end else if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(size)) begin
                    mem[addr + AW'(i)] <= 8'(wdata >> (8 * (int'(size) - 1 - i)));
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: one outstanding request, fixed access latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [SIZE_W-1:0] req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    req_t                req_q, req_d;
    logic                req_ready_d;
    logic                rsp_valid_d;
    logic                rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                we_c;
    logic                err_c;
    logic [DATA_W-1:0]   rd_c;
    logic [DATA_W:0]     end_addr_c;

    // One extra bit keeps addresses near 2^64 from wrapping into range.
    assign end_addr_c = {1'b0, req_q.addr} + (DATA_W+1)'(req_q.size);
    assign err_c      = !size_legal(req_q.size)
                     || ((req_q.addr[2:0] & align_mask(req_q.size)) != 3'd0)
                     || (end_addr_c > (DATA_W+1)'(DEPTH_BYTES));

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .addr    (req_q.addr[AW-1:0]),
        .size    (req_q.size),
        .we      (we_c),
        .wdata   (req_q.wdata),
        .rdata_c (rd_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        we_c        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.addr  = req_addr;
                    req_d.write = req_write;
                    req_d.wdata = req_wdata;
                    req_d.size  = req_size;
                    cnt_d       = CW'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    if (err_c) begin
                        rsp_err_d = 1'b1;
                    end else if (req_q.write) begin
                        we_c = 1'b1;
                    end else begin
                        rsp_rdata_d = rd_c;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 5) against a transaction-level model.
module tb_dmem_responder;

    localparam int NI  = 3;
    localparam int DEP = 64;
    localparam int PER = 10;

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    endfunction

    logic        clk;
    logic        reset;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [63:0] req_addr  [NI];
    logic        req_write [NI];
    logic [63:0] req_wdata [NI];
    logic [3:0]  req_size  [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [63:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    int vecs = 0;
    int errs = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_BYTES (DEP),
            .LATENCY     (lat_of(g))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_write (req_write[g]),
            .req_wdata (req_wdata[g]),
            .req_size  (req_size[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: phase 0 = free, 1 = accepted and waiting, 2 = response outstanding.
    logic [7:0]  mmem [NI][DEP];
    int          ph   [NI];
    int          age  [NI];
    logic [63:0] ma   [NI];
    logic [63:0] mwd  [NI];
    logic [3:0]  ms   [NI];
    logic        mwr  [NI];
    logic [63:0] ed   [NI];
    logic        er   [NI];

    task automatic model_commit(input int g);
        bit legal;
        legal = 1'b1;
        if (!(ms[g] inside {4'd1, 4'd2, 4'd4, 4'd8})) legal = 1'b0;
        else if ((ma[g] % 64'(ms[g])) != 64'd0) legal = 1'b0;
        else if (ma[g] > 64'(DEP) || 64'(ms[g]) > 64'(DEP) - ma[g]) legal = 1'b0;
        ed[g] = 64'd0;
        er[g] = !legal;
        if (legal && mwr[g]) begin
            for (int i = 0; i < int'(ms[g]); i++)
                mmem[g][int'(ma[g][6:0]) + i] = 8'(mwd[g] >> (8 * (int'(ms[g]) - 1 - i)));
        end else if (legal) begin
            for (int i = 0; i < int'(ms[g]); i++)
                ed[g] = ed[g] * 64'd256 + 64'(mmem[g][int'(ma[g][6:0]) + i]);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < NI; g++) begin
                for (int i = 0; i < DEP; i++) mmem[g][i] = 8'h00;
                ph[g] = 0; age[g] = 0; ed[g] = 64'd0; er[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                case (ph[g])
                    0: if (req_valid[g]) begin
                        ma[g] = req_addr[g]; mwd[g] = req_wdata[g];
                        ms[g] = req_size[g]; mwr[g] = req_write[g];
                        age[g] = 0; ph[g] = 1;
                    end
                    1: begin
                        age[g]++;
                        if (age[g] == int'(lat_of(g))) begin
                            model_commit(g);
                            ph[g] = 2;
                        end
                    end
                    default: if (rsp_ready[g]) begin
                        ph[g] = 0; ed[g] = 64'd0; er[g] = 1'b0;
                    end
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("u%0d.req_ready", g), 64'(req_ready[g]), 64'(ph[g] == 0));
            chk($sformatf("u%0d.rsp_valid", g), 64'(rsp_valid[g]), 64'(ph[g] == 2));
            chk($sformatf("u%0d.rsp_rdata", g), rsp_rdata[g], ed[g]);
            chk($sformatf("u%0d.rsp_err", g), 64'(rsp_err[g]), 64'(er[g]));
        end
    end

    time last_acc [NI];

    // Call at a negedge with instance g idle; acceptance happens at the next posedge.
    task automatic do_req(input int g, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                          input logic [3:0] sz, input logic [63:0] xd, input bit xe,
                          input int hold, input bit chk_per, input string nm);
        int  n;
        time t;
        logic [63:0] held;
        rsp_ready[g] = (hold == 0);
        req_valid[g] = 1'b1; req_write[g] = wr; req_addr[g] = a;
        req_wdata[g] = wd; req_size[g] = sz;
        @(posedge clk);
        t = $time;
        if (chk_per)
            chk({nm, ".period"}, 64'(t - last_acc[g]), 64'((lat_of(g) + 2) * PER));
        last_acc[g] = t;
        @(negedge clk);
        req_valid[g] = 1'b0;
        n = 1;
        while (!rsp_valid[g] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".latency"}, 64'(n), 64'(lat_of(g) + 1));
        chk({nm, ".rdata"}, rsp_rdata[g], xd);
        chk({nm, ".err"}, 64'(rsp_err[g]), 64'(xe));
        held = rsp_rdata[g];
        for (int h = 0; h < hold; h++) begin
            req_valid[g] = 1'b1; req_write[g] = 1'b1; req_addr[g] = 64'd0;
            req_wdata[g] = 64'hFF; req_size[g] = 4'd1;
            @(negedge clk);
            chk({nm, ".hold_valid"}, 64'(rsp_valid[g]), 64'd1);
            chk({nm, ".hold_rdata"}, rsp_rdata[g], held);
            chk({nm, ".hold_ready"}, 64'(req_ready[g]), 64'd0);
        end
        req_valid[g] = 1'b0;
        rsp_ready[g] = 1'b1;
        @(negedge clk);
        chk({nm, ".idle_after"}, 64'(req_ready[g]), 64'd1);
    endtask

    initial begin
        #(PER * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0; req_write[g] = 1'b0; req_addr[g] = 64'd0;
            req_wdata[g] = 64'd0; req_size[g] = 4'd0; rsp_ready[g] = 1'b1;
            last_acc[g] = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset.req_ready", 64'(req_ready[0]), 64'd1);
        chk("reset.rsp_valid", 64'(rsp_valid[0]), 64'd0);

        // LATENCY=2: store/load, sub-word loads, errors, backpressure
        do_req(0, 1, 64'd8, 64'h0123456789ABCDEF, 4'd8, 64'd0, 0, 0, 0, "st8");
        do_req(0, 0, 64'd8, 64'd0, 4'd8, 64'h0123456789ABCDEF, 0, 0, 0, "ld8");
        do_req(0, 0, 64'd8, 64'd0, 4'd1, 64'h01, 0, 0, 0, "ld8b");
        do_req(0, 0, 64'd10, 64'd0, 4'd2, 64'h4567, 0, 0, 0, "ld10h");
        do_req(0, 0, 64'd12, 64'd0, 4'd4, 64'h89ABCDEF, 0, 0, 0, "ld12w");
        do_req(0, 0, 64'd9, 64'd0, 4'd2, 64'd0, 1, 0, 0, "misalign");
        do_req(0, 0, 64'd64, 64'd0, 4'd8, 64'd0, 1, 0, 0, "range");
        do_req(0, 0, 64'd0, 64'd0, 4'd3, 64'd0, 1, 0, 0, "size3");
        do_req(0, 0, 64'd0, 64'd0, 4'd0, 64'd0, 1, 0, 0, "size0");
        do_req(0, 1, 64'hFFFFFFFFFFFFFFF8, 64'hDEADDEADDEADDEAD, 4'd8, 64'd0, 1, 0, 0, "wrap");
        do_req(0, 0, 64'd0, 64'd0, 4'd8, 64'd0, 0, 0, 0, "ld0");
        do_req(0, 1, 64'd56, 64'hA1A2A3A4A5A6A7A8, 4'd8, 64'd0, 0, 0, 0, "st56");
        do_req(0, 0, 64'd63, 64'd0, 4'd1, 64'hA8, 0, 0, 0, "ld63b");
        do_req(0, 0, 64'd60, 64'd0, 4'd8, 64'd0, 1, 0, 0, "ld60d");
        do_req(0, 0, 64'd8, 64'd0, 4'd8, 64'h0123456789ABCDEF, 0, 5, 0, "bp");

        // Reset while a store waits for its commit edge
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'd3;
        req_wdata[0] = 64'hAA; req_size[0] = 4'd1;
        @(posedge clk);
        #2;
        req_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_wait.req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_wait.rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_wait.rsp_rdata", rsp_rdata[0], 64'd0);
        chk("rst_wait.rsp_err", 64'(rsp_err[0]), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(0, 0, 64'd0, 64'd0, 4'd8, 64'd0, 0, 0, 0, "post_rst0");
        do_req(0, 0, 64'd8, 64'd0, 4'd8, 64'd0, 0, 0, 0, "post_rst8");

        // LATENCY=1 back-to-back; upper wdata bits must be ignored
        do_req(1, 1, 64'd0, 64'hFFFFFFFFDEADBEEF, 4'd4, 64'd0, 0, 0, 0, "l1.st0");
        do_req(1, 0, 64'd0, 64'd0, 4'd4, 64'hDEADBEEF, 0, 0, 1, "l1.ld0w");
        do_req(1, 0, 64'd0, 64'd0, 4'd2, 64'hDEAD, 0, 0, 1, "l1.ld0h");
        do_req(1, 0, 64'd2, 64'd0, 4'd1, 64'hBE, 0, 0, 1, "l1.ld2b");
        do_req(1, 1, 64'd16, 64'hFFFF1234, 4'd2, 64'd0, 0, 0, 1, "l1.st16");
        do_req(1, 0, 64'd16, 64'd0, 4'd4, 64'h12340000, 0, 0, 1, "l1.ld16w");

        // LATENCY=5 back-to-back
        do_req(2, 1, 64'd32, 64'h1122334455667788, 4'd8, 64'd0, 0, 0, 0, "l5.st32");
        do_req(2, 0, 64'd36, 64'd0, 4'd4, 64'h55667788, 0, 0, 1, "l5.ld36w");
        do_req(2, 0, 64'd33, 64'd0, 4'd1, 64'h22, 0, 0, 1, "l5.ld33b");
        do_req(2, 0, 64'd62, 64'd0, 4'd2, 64'h0000, 0, 0, 1, "l5.ld62h");
        do_req(2, 0, 64'd60, 64'd0, 4'd8, 64'd0, 1, 0, 1, "l5.ld60d");
        do_req(2, 0, 64'd32, 64'd0, 4'd8, 64'h1122334455667788, 0, 0, 1, "l5.ld32d");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
